// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FP32 constants, divider state encoding and operand classification.
package fpu_pkg;
  localparam int FP_BIAS = 127;
  localparam logic [31:0] FP_QNAN = 32'h7FC00000;
  localparam logic [31:0] FP_PINF = 32'h7F800000;
  typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} fdiv_state_t;
  typedef struct packed {
    logic is_zero;
    logic is_inf;
    logic is_nan;
  } fp_class_t;
  // Exponent-0 encodings count as zero, so subnormals flush on input.
  function automatic fp_class_t classify(input logic [31:0] x);
    fp_class_t c;
    c.is_zero = x[30:23] == 8'd0;
    c.is_inf  = x[30:23] == 8'hFF && x[22:0] == 23'd0;
    c.is_nan  = x[30:23] == 8'hFF && x[22:0] != 23'd0;
    return c;
  endfunction
endpackage

// File: rtl/fp_round_pack.sv
// fp_round_pack: normalize a 27-bit quotient, round to nearest even, range check and pack FP32.
module fp_round_pack
  import fpu_pkg::*;
(
  input  logic        [26:0] q,
  input  logic               rem_nz,
  input  logic signed [9:0]  exp_in,
  input  logic               sign,
  output logic        [31:0] res
);
  logic [23:0] mant, mant_f;
  logic guard, sticky, inc, carry;
  logic [23:0] mant_r;
  logic signed [9:0] e_n, e_f;
  always_comb begin
    mant = q[26] ? q[26:3] : q[25:2];
    guard = q[26] ? q[2] : q[1];
    sticky = (q[26] ? |q[1:0] : q[0]) | rem_nz;
    inc = guard & (sticky | mant[0]);
    {carry, mant_r} = {1'b0, mant} + {24'd0, inc};
    mant_f = carry ? 24'h800000 : mant_r;
    e_n = q[26] ? exp_in : exp_in - 10'sd1;
    e_f = e_n + $signed({9'd0, carry});
    res = e_f >= 10'sd255 ? {sign, FP_PINF[30:0]} :
          e_f <= 10'sd0   ? {sign, 31'd0} :
                            {sign, e_f[7:0], mant_f[22:0]};
  end
endmodule

// File: rtl/fdiv_seq.sv
// fdiv_seq: iterative FP32 divider, radix-2 restoring, one quotient bit per cycle, RNE rounding.
module fdiv_seq
  import fpu_pkg::*;
#(
  parameter bit SPECIAL_FAST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] num1,
  input  logic [31:0] num2,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_div,
  output logic        out_valid,
  input  logic        out_ready
);
  fdiv_state_t state, state_n;
  logic [4:0] cnt;
  logic [24:0] rem;
  logic [23:0] mb, rem_n;
  logic [26:0] q;
  logic signed [9:0] e;
  logic sign, spec, ge;
  logic [31:0] spec_res, spec_c, rp_res;
  fp_class_t ca, cb;
  logic acc, sp_c, sgn_c;
  always_comb begin
    ca = classify(num1);
    cb = classify(num2);
    sgn_c = num1[31] ^ num2[31];
    sp_c = ca.is_nan | cb.is_nan | ca.is_zero | cb.is_zero | ca.is_inf | cb.is_inf;
    spec_c = (ca.is_nan | cb.is_nan | (ca.is_zero & cb.is_zero) | (ca.is_inf & cb.is_inf)) ? FP_QNAN :
             (ca.is_inf | cb.is_zero) ? {sgn_c, FP_PINF[30:0]} : {sgn_c, 31'd0};
    acc = in_valid && state == IDLE;
    ge = rem >= {1'b0, mb};
    rem_n = ge ? 24'(rem - {1'b0, mb}) : rem[23:0];
    in_ready = state == IDLE;
    out_valid = state == DONE;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  state_n = acc ? ((sp_c && SPECIAL_FAST) ? DONE : DIV) : IDLE;
      DIV:   state_n = cnt == 5'd0 ? ROUND : DIV;
      ROUND: state_n = DONE;
      DONE:  state_n = out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  fp_round_pack u_rp (
    .q(q),
    .rem_nz(rem != 25'd0),
    .exp_in(e),
    .sign(sign),
    .res(rp_res)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      rem <= '0;
      mb <= '0;
      q <= '0;
      e <= '0;
      sign <= 1'b0;
      spec <= 1'b0;
      spec_res <= '0;
      out_div <= '0;
    end else begin
      if (acc) begin
        cnt <= 5'd26;
        rem <= {2'b01, num1[22:0]};
        mb <= {1'b1, num2[22:0]};
        q <= '0;
        e <= 10'({2'b0, num1[30:23]} - {2'b0, num2[30:23]} + 10'(FP_BIAS));
        sign <= sgn_c;
        spec <= sp_c;
        spec_res <= spec_c;
        if (sp_c && SPECIAL_FAST) out_div <= spec_c;
      end
      if (state == DIV) begin
        rem <= {rem_n, 1'b0};
        q <= {q[25:0], ge};
        cnt <= cnt - 5'd1;
      end
      if (state == ROUND) out_div <= spec ? spec_res : rp_res;
    end
  end
endmodule

// File: tb/tb_fdiv_seq.sv
// tb_fdiv_seq: directed vectors with hand-computed quotients, latency, backpressure and reset checks.
module tb_fdiv_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] num1 = '0, num2 = '0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid;
  logic [31:0] out_div;
  int checks = 0, errors = 0;
  int lat;
  logic busy_bad;
  always #5 clk = ~clk;
  fdiv_seq dut (
    .clk(clk), .rst(rst), .num1(num1), .num2(num2), .in_valid(in_valid),
    .in_ready(in_ready), .out_div(out_div), .out_valid(out_valid), .out_ready(out_ready)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    num1 = a;
    num2 = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic wait_done();
    lat = 1;
    busy_bad = 1'b0;
    while (!out_valid && lat < 40) begin
      busy_bad |= in_ready;
      @(posedge clk);
      #1 lat++;
    end
  endtask
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat);
    start(a, b);
    wait_done();
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_busy"}, {31'd0, busy_bad}, 32'd0);
    chk({tag, "_res"}, out_div, exp);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({tag, "_idle"}, {31'd0, in_ready}, 32'd1);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_div", out_div, 32'd0);
    run_op("six_by_two", 32'h40C00000, 32'h40000000, 32'h40400000, 29);
    run_op("one_third", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 29);
    run_op("one_by_zero", 32'h3F800000, 32'h00000000, 32'h7F800000, 1);
    run_op("neg_by_zero", 32'hBF800000, 32'h00000000, 32'hFF800000, 1);
    run_op("zero_by_zero", 32'h00000000, 32'h00000000, 32'h7FC00000, 1);
    run_op("inf_by_inf", 32'h7F800000, 32'h7F800000, 32'h7FC00000, 1);
    run_op("overflow", 32'h7F000000, 32'h00800000, 32'h7F800000, 29);
    run_op("underflow", 32'h00800000, 32'h40000000, 32'h00000000, 29);
    run_op("ftz_in", 32'h00400000, 32'h3F800000, 32'h00000000, 1);
    run_op("neg_six", 32'hC0C00000, 32'h40000000, 32'hC0400000, 29);
    start(32'h3F800000, 32'h40000000);
    wait_done();
    chk("bp_lat", 32'(lat), 32'd29);
    num1 = 32'h40800000;
    num2 = 32'h3F800000;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold", out_div, 32'h3F000000);
      chk("bp_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b0;
    run_op("after_bp", 32'h40800000, 32'h3F800000, 32'h40800000, 29);
    start(32'h40C00000, 32'h40000000);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midrst_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_div", out_div, 32'd0);
    run_op("post_rst", 32'h40800000, 32'h40000000, 32'h40000000, 29);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
